// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// master drives operands and out_ready; slave is the divider.
interface seq_divider_if #(
    parameter int word_width = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [word_width-1:0] dividend;
    logic [word_width-1:0] divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [word_width-1:0] quotient;
    logic [word_width-1:0] remainder;
    logic                  div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Trial subtraction runs through a grouped carry-lookahead adder.
module seq_divider #(
    parameter int word_width   = 16,
    parameter int cascade_size = 4
) (
    input logic         clk,
    input logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int aw = word_width + 1;
    localparam int cs = cascade_size;
    localparam int ng = (aw + cs - 1) / cs;
    localparam int cw = $clog2(word_width);
    localparam logic [cw-1:0] last = cw'(word_width - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state;
    state_t                state_nx;
    logic [word_width-1:0] qreg;
    logic [word_width-1:0] rem;
    logic [word_width-1:0] dvsr;
    logic                  dbz;
    logic [cw-1:0]         cnt;

    logic [word_width-1:0] partial;
    logic [word_width-1:0] trial_lo;
    logic                  nonneg;
    logic [aw-1:0]         add_a;
    logic [aw-1:0]         add_b;
    logic [aw-1:0]         prop;
    logic [aw-1:0]         gen;
    logic [aw-2:0]         carry;
    logic [ng-1:0]         grp_g;
    logic [ng-1:0]         grp_p;
    logic [ng:0]           gcarry;

    assign partial = {rem[word_width-2:0], qreg[word_width-1]};
    assign add_a   = {1'b0, partial};
    assign add_b   = ~{1'b0, dvsr};
    assign prop    = add_a ^ add_b;
    assign gen     = add_a & add_b;

    always_comb begin
        grp_g = '0;
        grp_p = '1;
        for (int i = 0; i < aw; i++) begin
            grp_g[i/cs] = gen[i] | (prop[i] & grp_g[i/cs]);
            grp_p[i/cs] = grp_p[i/cs] & prop[i];
        end
    end

    // carry-in 1 turns a + ~b into a - b
    always_comb begin
        gcarry    = '0;
        gcarry[0] = 1'b1;
        for (int g = 0; g < ng; g++)
            gcarry[g+1] = grp_g[g] | (grp_p[g] & gcarry[g]);
    end

    always_comb begin
        carry    = '0;
        carry[0] = gcarry[0];
        for (int i = 1; i < aw - 1; i++)
            carry[i] = (i % cs == 0) ? gcarry[i/cs]
                     : (gen[i-1] | (prop[i-1] & carry[i-1]));
    end

    // carry-out set means no borrow: trial sign bit is 0
    assign trial_lo = prop[aw-2:0] ^ carry;
    assign nonneg   = gcarry[ng];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid)
                    state_nx = (bus.divisor == '0) ? DONE : CALC;
            end
            CALC: if (cnt == last) state_nx = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qreg <= '0;
            rem  <= '0;
            dvsr <= '0;
            dbz  <= 1'b0;
            cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    cnt  <= '0;
                    dvsr <= bus.divisor;
                    if (bus.divisor == '0) begin
                        qreg <= '1;
                        rem  <= bus.dividend;
                        dbz  <= 1'b1;
                    end else begin
                        qreg <= bus.dividend;
                        rem  <= '0;
                        dbz  <= 1'b0;
                    end
                end
                CALC: begin
                    qreg <= {qreg[word_width-2:0], nonneg};
                    rem  <= nonneg ? trial_lo : partial;
                    cnt  <= (cnt == last) ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = qreg;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, corner
// sequences and a random sweep, with a result scoreboard.
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    seq_divider_if #(.word_width(16)) bus();

    seq_divider #(.word_width(16), .cascade_size(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // mode 0: ready high; 1: hold off `hold` cycles with a stray
    // in_valid pulse; 2: random out_ready plus identity checks
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input exp_t e, input int mode, input int hold);
        int   n;
        exp_t x;
        logic rel;
        n = 0;
        while (!bus.in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 64), 32'd1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 16'($urandom);
        n = 1;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(e.lat));
        x   = sb.pop_front();
        n   = 0;
        rel = 1'b0;
        while (!rel && n < 40) begin
            chk("out_valid", 32'(bus.out_valid), 32'd1);
            chk("quotient", 32'(bus.quotient), 32'(x.q));
            chk("remainder", 32'(bus.remainder), 32'(x.r));
            chk("div_by_zero", 32'(bus.div_by_zero), 32'(x.dbz));
            chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
            if (mode == 2 && n == 0 && b != 16'd0) begin
                chk("identity", 32'(bus.quotient) * 32'(b)
                    + 32'(bus.remainder), 32'(a));
                chk("rem_lt_div", 32'(bus.remainder < b), 32'd1);
            end
            case (mode)
                0: bus.out_ready = 1'b1;
                1: begin
                    bus.out_ready = (n >= hold);
                    bus.in_valid  = (n == 2);
                    bus.dividend  = 16'd9999;
                    bus.divisor   = 16'd3;
                end
                default: bus.out_ready = (n >= 10) ? 1'b1
                                         : 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            rel = bus.out_ready;
            n++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        exp_t        e;

        vecs[0] = '{16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 17};
        vecs[1] = '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0,     1'b0, 17};
        vecs[2] = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,     1'b0, 17};
        vecs[3] = '{16'd3,     16'd10,    16'd0,     16'd3,     1'b0, 17};
        vecs[4] = '{16'd5,     16'd0,     16'hFFFF,  16'd5,     1'b1, 1};
        vecs[5] = '{16'd9,     16'd3,     16'd3,     16'd0,     1'b0, 17};
        vecs[6] = '{16'd0,     16'd5,     16'd0,     16'd0,     1'b0, 17};
        vecs[7] = '{16'hFFFE,  16'hFFFF,  16'd0,     16'hFFFE,  1'b0, 17};
        vecs[8] = '{16'h8000,  16'h7FFF,  16'd1,     16'd1,     1'b0, 17};
        vecs[9] = '{16'd0,     16'd0,     16'hFFFF,  16'd0,     1'b1, 1};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_quotient", 32'(bus.quotient), 32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            e = '{vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat};
            run_op(vecs[i].a, vecs[i].b, e, 0, 0);
        end

        run_op(16'd1234, 16'd56, '{16'd22, 16'd2, 1'b0, 17}, 1, 5);

        bus.in_valid = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_quotient", 32'(bus.quotient), 32'd0);
        chk("abort_remainder", 32'(bus.remainder), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'd50, 16'd7, '{16'd7, 16'd1, 1'b0, 17}, 0, 0);

        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 9))
                0: b = 16'd0;
                1: b = 16'($urandom_range(1, 15));
                2: a = 16'($urandom_range(0, 15));
                default: ;
            endcase
            if (b == 16'd0) e = '{16'hFFFF, a, 1'b1, 1};
            else            e = '{a / b, a % b, 1'b0, 17};
            run_op(a, b, e, 2, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
